fb_port_arbiter: RTL and testbench

Shares the single read/write port of the frame-buffer BRAM between the camera pixel writer and the VGA pixel reader. Sits between the OV7670 capture/filter chain and the VGA sync generator: the sync generator's column/row/pixel-strobe drives the read schedule, and camera writes are buffered in a small FIFO and drained into the remaining memory slots. Output is one 8-bit pixel per VGA pixel period, black outside the image window.

---
 rtl/fb_port_arbiter_pkg.sv | 23 ++
 rtl/fb_port_arbiter_if.sv | 41 ++++
 rtl/fb_wr_fifo.sv | 69 ++++++
 rtl/fb_port_arbiter.sv | 111 +++++++++++
 tb/tb_fb_port_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fb_port_arbiter_pkg.sv
// Frame-buffer geometry and widths shared by the capture writer, the port arbiter and the VGA top.
package fb_port_arbiter_pkg;

  localparam int unsigned c_img_cols = 160;
  localparam int unsigned c_img_rows = 120;
  localparam int unsigned c_nb_addr  = 15;
  localparam int unsigned c_nb_data  = 8;
  localparam int unsigned c_nb_fifo  = 2;
  localparam int unsigned c_nb_vga   = 10;

  // Camera write request as it travels through the write FIFO.
  typedef struct packed {
    logic [c_nb_addr-1:0] addr;
    logic [c_nb_data-1:0] data;
  } fb_wr_t;

  // Half of a VGA pixel period, selected by the pixel strobe.
  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// VGA schedule, camera write and BRAM port signals of the frame-buffer arbiter.
interface fb_port_arbiter_if #(
  parameter int unsigned nb_addr = fb_port_arbiter_pkg::c_nb_addr,
  parameter int unsigned nb_data = fb_port_arbiter_pkg::c_nb_data
);
  import fb_port_arbiter_pkg::*;

  logic                vga_new_pxl;
  logic                vga_visible;
  logic [c_nb_vga-1:0] vga_col;
  logic [c_nb_vga-1:0] vga_row;
  logic [nb_data-1:0]  vga_pxl;

  logic                cam_wr_req;
  logic [nb_addr-1:0]  cam_wr_addr;
  logic [nb_data-1:0]  cam_wr_data;
  logic                cam_fifo_full;
  logic                wr_overflow;

  logic [nb_addr-1:0]  mem_addr;
  logic                mem_we;
  logic [nb_data-1:0]  mem_wdata;
  logic [nb_data-1:0]  mem_rdata;

  modport slave (
    input  vga_new_pxl, vga_visible, vga_col, vga_row,
    input  cam_wr_req, cam_wr_addr, cam_wr_data,
    input  mem_rdata,
    output vga_pxl, cam_fifo_full, wr_overflow,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_new_pxl, vga_visible, vga_col, vga_row,
    output cam_wr_req, cam_wr_addr, cam_wr_data,
    output mem_rdata,
    input  vga_pxl, cam_fifo_full, wr_overflow,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering camera writes until a free BRAM slot comes up.
module fb_wr_fifo #(
  parameter int unsigned c_nb_width = 23,
  parameter int unsigned c_nb_fifo  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [c_nb_width-1:0] wdata,
  input  logic                  pop,
  output logic [c_nb_width-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned        c_depth   = 2**c_nb_fifo;
  localparam logic [c_nb_fifo:0] c_cnt_max = (c_nb_fifo+1)'(c_depth);
  localparam logic [c_nb_fifo:0] c_cnt_one = (c_nb_fifo+1)'(1);
  localparam logic [c_nb_fifo-1:0] c_ptr_one = c_nb_fifo'(1);

  logic [c_nb_width-1:0] mem_q [c_depth];
  logic [c_nb_width-1:0] mem_d [c_depth];
  logic [c_nb_fifo-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_nb_fifo-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_nb_fifo:0]    count_q, count_d;
  logic                  do_push, do_pop;

  // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
  always_comb begin
    full     = (count_q == c_cnt_max);
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    rdata    = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + c_ptr_one;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single frame-buffer BRAM port: VGA reads take slot A inside the image window,
// buffered camera writes take every other cycle.
module fb_port_arbiter #(
  parameter int unsigned c_img_cols = fb_port_arbiter_pkg::c_img_cols,
  parameter int unsigned c_img_rows = fb_port_arbiter_pkg::c_img_rows,
  parameter int unsigned c_nb_addr  = fb_port_arbiter_pkg::c_nb_addr,
  parameter int unsigned c_nb_data  = fb_port_arbiter_pkg::c_nb_data,
  parameter int unsigned c_nb_fifo  = fb_port_arbiter_pkg::c_nb_fifo
) (
  input logic              clk,
  input logic              rst,
  fb_port_arbiter_if.slave bus
);
  import fb_port_arbiter_pkg::slot_e;
  import fb_port_arbiter_pkg::SLOT_A;
  import fb_port_arbiter_pkg::SLOT_B;
  import fb_port_arbiter_pkg::c_nb_vga;

  localparam int unsigned         c_nb_ent  = c_nb_addr + c_nb_data;
  localparam logic [c_nb_vga-1:0] c_col_lim = c_nb_vga'(c_img_cols);
  localparam logic [c_nb_vga-1:0] c_row_lim = c_nb_vga'(c_img_rows);
  localparam logic [c_nb_addr-1:0] c_addr_one = c_nb_addr'(1);

  logic [c_nb_addr-1:0] rd_cnt_q, rd_cnt_d;
  logic                 rd_pending_q, rd_pending_d;
  logic [c_nb_data-1:0] vga_pxl_q, vga_pxl_d;
  logic                 wr_overflow_q, wr_overflow_d;

  slot_e                slot;
  logic                 in_win, rd_slot;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [c_nb_ent-1:0]  fifo_wdata, fifo_rdata;

  // Slot decode: only slot A inside the window belongs to the reader.
  always_comb begin
    slot       = slot_e'(bus.vga_new_pxl);
    in_win     = bus.vga_visible && (bus.vga_col < c_col_lim) && (bus.vga_row < c_row_lim);
    rd_slot    = (slot == SLOT_A) && in_win;
    fifo_pop   = !rd_slot && !fifo_empty;
    fifo_push  = bus.cam_wr_req && !fifo_full;
    fifo_wdata = {bus.cam_wr_addr, bus.cam_wr_data};
  end

  fb_wr_fifo #(
    .c_nb_width (c_nb_ent),
    .c_nb_fifo  (c_nb_fifo)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // BRAM port is combinational from registered state so the address lands in its own slot.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (rd_slot) begin
      bus.mem_addr = rd_cnt_q;
    end else if (fifo_pop) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fifo_rdata[c_nb_ent-1 -: c_nb_addr];
      bus.mem_wdata = fifo_rdata[c_nb_data-1:0];
    end
  end

  always_comb begin
    rd_cnt_d      = rd_cnt_q;
    rd_pending_d  = rd_pending_q;
    vga_pxl_d     = vga_pxl_q;
    wr_overflow_d = wr_overflow_q | (bus.cam_wr_req & fifo_full);
    if (rd_slot) begin
      rd_pending_d = 1'b1;
    end
    if (slot == SLOT_B) begin
      vga_pxl_d    = rd_pending_q ? bus.mem_rdata : '0;
      rd_pending_d = 1'b0;
      if (rd_pending_q) begin
        rd_cnt_d = rd_cnt_q + c_addr_one;
      end
    end
    // Any line below the image rewinds the read pointer for the next frame.
    if (bus.vga_row >= c_row_lim) begin
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q      <= '0;
      rd_pending_q  <= 1'b0;
      vga_pxl_q     <= '0;
      wr_overflow_q <= 1'b0;
    end else begin
      rd_cnt_q      <= rd_cnt_d;
      rd_pending_q  <= rd_pending_d;
      vga_pxl_q     <= vga_pxl_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  assign bus.vga_pxl       = vga_pxl_q;
  assign bus.wr_overflow   = wr_overflow_q;
  assign bus.cam_fifo_full = fifo_full;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: drives a compressed VGA schedule plus camera writes
// against a 1-cycle-latency BRAM model.
module tb_fb_port_arbiter;
  import fb_port_arbiter_pkg::*;

  localparam int unsigned c_pix   = c_img_cols * c_img_rows;
  localparam int          c_depth = 2**c_nb_fifo;
  localparam int          c_line  = 164;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  fb_port_arbiter_if bus ();

  fb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM model, read-first, preloaded with mem[a] = a[7:0].
  logic [c_nb_data-1:0] bram [2**c_nb_addr];
  initial begin
    for (int i = 0; i < 2**c_nb_addr; i++) bram[i] <= c_nb_data'(i);
  end
  always @(posedge clk) begin
    bus.mem_rdata <= bram[bus.mem_addr];
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
  end

  int n_chk;
  int n_err;
  fb_wr_t               wr_q[$];
  logic [c_nb_data-1:0] pix_q[$];
  int                   m_cnt;
  bit                   m_ovf;
  logic [c_nb_addr-1:0] wa;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the BRAM port and FIFO flags against the model, advance.
  task automatic cyc(input bit sb, input int col, input int row, input bit vis,
                     input bit req, output bit we_seen);
    bit     in_win, rd_slot, full_m, pop_m;
    fb_wr_t ent;
    logic [c_nb_data-1:0] d;
    d = c_nb_data'($urandom);
    bus.vga_new_pxl = sb;
    bus.vga_col     = 10'(col);
    bus.vga_row     = 10'(row);
    bus.vga_visible = vis;
    bus.cam_wr_req  = req;
    bus.cam_wr_addr = wa;
    bus.cam_wr_data = d;
    #2;
    in_win  = vis && (col < int'(c_img_cols)) && (row < int'(c_img_rows));
    rd_slot = !sb && in_win;
    full_m  = (m_cnt == c_depth);
    pop_m   = !rd_slot && (m_cnt > 0);
    check_eq("fifo_full", 32'(bus.cam_fifo_full), 32'(full_m));
    check_eq("wr_overflow", 32'(bus.wr_overflow), 32'(m_ovf));
    check_eq("mem_we", 32'(bus.mem_we), 32'(pop_m));
    if (rd_slot) begin
      check_eq("rd_addr", 32'(bus.mem_addr), row * int'(c_img_cols) + col);
    end else if (pop_m) begin
      ent = wr_q.pop_front();
      check_eq("wr_addr", 32'(bus.mem_addr), 32'(ent.addr));
      check_eq("wr_data", 32'(bus.mem_wdata), 32'(ent.data));
    end else begin
      check_eq("idle_addr", 32'(bus.mem_addr), 0);
    end
    if (pop_m) m_cnt--;
    if (req) begin
      if (full_m) begin
        m_ovf = 1'b1;
      end else begin
        ent.addr = wa;
        ent.data = d;
        wr_q.push_back(ent);
        m_cnt++;
        wa = (wa == '1) ? c_nb_addr'(c_pix) : wa + c_nb_addr'(1);
      end
    end
    we_seen = bus.mem_we;
    @(posedge clk);
    #1;
    bus.cam_wr_req = 1'b0;
  endtask

  // One VGA pixel period (slots A and B); the pixel shows on vga_pxl right after slot B.
  task automatic pixel(input int col, input int row, input bit vis,
                       input bit req_a, input bit req_b, output int nwr);
    bit w0, w1;
    bit in_win;
    logic [c_nb_data-1:0] exp;
    in_win = vis && (col < int'(c_img_cols)) && (row < int'(c_img_rows));
    pix_q.push_back(in_win ? c_nb_data'(row * int'(c_img_cols) + col) : '0);
    cyc(1'b0, col, row, vis, req_a, w0);
    cyc(1'b1, col, row, vis, req_b, w1);
    nwr = int'(w0) + int'(w1);
    exp = pix_q.pop_front();
    check_eq("vga_pxl", 32'(bus.vga_pxl), 32'(exp));
  endtask

  // Reset applied while an in-window slot A is presented.
  task automatic do_reset();
    bus.vga_new_pxl = 1'b0;
    bus.vga_visible = 1'b1;
    bus.vga_col     = 10'd16;
    bus.vga_row     = 10'd0;
    bus.cam_wr_req  = 1'b0;
    rst = 1'b1;
    #2;
    check_eq("rst_vga_pxl", 32'(bus.vga_pxl), 0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check_eq("rst_fifo_full", 32'(bus.cam_fifo_full), 0);
    check_eq("rst_overflow", 32'(bus.wr_overflow), 0);
    m_cnt = 0;
    m_ovf = 1'b0;
    wr_q.delete();
    pix_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int line_col(input int c);
    return (c < 162) ? c : ((c == 162) ? 200 : 640);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nwr;
    n_chk = 0;
    n_err = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    wa    = c_nb_addr'(c_pix);
    rst   = 1'b1;
    bus.cam_wr_req  = 1'b0;
    bus.cam_wr_addr = '0;
    bus.cam_wr_data = '0;
    bus.vga_new_pxl = 1'b0;
    bus.vga_visible = 1'b0;
    bus.vga_col     = '0;
    bus.vga_row     = '0;
    #1;
    do_reset();

    // Full frame with one camera write every 4 clk; col 200 and row 130 lie outside the image.
    for (int r = 0; r < int'(c_img_rows); r++) begin
      for (int c = 0; c < c_line; c++) begin
        pixel(line_col(c), r, c != c_line - 1, (c % 2) == 0, 1'b0, nwr);
      end
    end
    for (int c = 0; c < 4; c++) pixel(c, 130, 1'b1, 1'b0, 1'b0, nwr);

    // Vertical blanking: back-to-back writes fill both slots of a pixel period.
    for (int c = 0; c < 8; c++) begin
      pixel(c, 480, 1'b0, c < 4, c < 4, nwr);
      if (c >= 1 && c < 4) check_eq("two_wr_per_pxl", nwr, 2);
    end

    // Next frame: burst of 12 requests in the window overflows the FIFO, then reset mid-line.
    for (int c = 0; c < 16; c++) pixel(c, 0, 1'b1, c >= 10, c >= 10, nwr);
    do_reset();
    for (int c = 0; c < 4; c++) pixel(c, 480, 1'b0, 1'b0, 1'b0, nwr);

    // Frame after the reset restarts reads at address 0.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < c_line; c++) begin
        pixel(line_col(c), r, c != c_line - 1, (c % 2) == 0, 1'b0, nwr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
